ins_fetcher: RTL
================

Name: ins_fetcher

Overview:
Instruction-fetch front end that supplies the decoder with instructions over the ins / ins_flag / ins_imm / rd_val interface.
- Holds the PC and fetches one 32-bit word at a time from the memory controller's instruction port.
- Generates the sign-extended immediate.
- Statically redirects on JAL and is re-steered by the ROB on mispredict or flush.
- Sits between the memory controller and the decoder; the decoder is combinational, so this block owns the one-cycle issue pulse.

Parameters:
RESET_PC, 32'h0, PC loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low freezes all state
- stall  in  1  ROB/LSB/RS full; no issue while high
- clr  in  1  flush from ROB (mispredict/JALR resolve)
- clr_pc  in  32  redirect target, valid with clr
- mc_ins_req  out  1  fetch request, registered, held until mc_ins_valid or abort
- mc_ins_addr  out  32  fetch address, registered, stable while mc_ins_req=1
- mc_ins_valid  in  1  one-cycle pulse, data returned
- mc_ins_data  in  32  fetched instruction word
- ins  out  32  instruction to decoder
- ins_flag  out  1  one-cycle issue strobe
- ins_imm  out  32  decoded immediate
- rd_val  out  32  PC of the issued instruction (for JAL/JALR/AUIPC link/offset)

Behaviour:
- Reset (sync, rst=1 at posedge):
  - pc=RESET_PC; state=IDLE.
  - mc_ins_req=0, mc_ins_addr=0.
  - ins=0, ins_flag=0, ins_imm=0, rd_val=0; buffer cleared.
- Reset mid-transaction abandons the request; memory controller is reset by the same rst.
- rdy=0: every register holds, except ins_flag, which is forced 0. A pending issue is retained and performed after rdy returns.
- Priority each cycle: rst > !rdy > clr > normal FSM.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE: next cycle mc_ins_req=1, mc_ins_addr=pc; go WAIT. A request is launched even while stall=1 (prefetch).
  - WAIT, mc_ins_valid=1, stall=0: issue; go IDLE.
  - WAIT, mc_ins_valid=1, stall=1: latch word into buffer; mc_ins_req=0; go HOLD.
  - WAIT, no valid: hold request unchanged.
  - HOLD, stall=0: issue from buffer; go IDLE.
  - HOLD, stall=1: remain in HOLD.
- Issue (registered):
  - ins=word, ins_imm=imm_gen(word), rd_val=pc.
  - ins_flag=1 for exactly one cycle.
  - pc=next_pc; mc_ins_req=0.
- Latency and throughput: mc_ins_valid to ins_flag = 1 cycle when not stalled. Minimum fetch-to-fetch spacing is issue, IDLE, request: new request the cycle after issue.
- next_pc:
  - opcode JAL: pc + J-imm, static taken.
  - all others, including branches (predict not-taken) and JALR: pc+4.
  - 32-bit wrap-around, no overflow detection.
- clr:
  - pc=clr_pc; state=IDLE; buffer dropped; mc_ins_req=0 next cycle (abort).
  - ins_flag=0 that cycle, even if an issue would have occurred.
  - mc_ins_valid coincident with clr is ignored.
  - The memory controller treats req deassertion as abort and never returns stale data afterwards.
- Immediate rules (opcode ins[6:0]):
  - LOAD, OP-IMM, JALR: sext(ins[31:20]).
  - SLLI/SRLI/SRAI (OP-IMM, funct3 001/101): zext(ins[24:20]); funct7 bits are excluded.
  - STORE: sext({ins[31:25],ins[11:7]}).
  - BRANCH: sext({ins[31],ins[7],ins[30:25],ins[11:8],1'b0}).
  - LUI/AUIPC: {ins[31:12],12'b0}.
  - JAL: sext({ins[31],ins[19:12],ins[20],ins[30:21],1'b0}).
  - OP (R-type) and unknown: 0.
- Unknown opcodes are still issued; the decoder maps them to opcode 0.

Decomposition:
- defines.v gains 7-bit opcode-head constants: OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_OPIMM, OPC_OP, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR.
- Add FSM state encodings IF_IDLE/IF_WAIT/IF_HOLD.
- One combinational sub-module, imm_gen (word in, 32-bit imm out). The decoder may later reuse it.

Test Plan:
1. Reset, PC=0, mem[0]=0x00500093 (addi x1,x0,5) -> mc_ins_addr=0; ins_flag high 1 cycle after valid; ins_imm=5, rd_val=0; next mc_ins_addr=4.
2. mem[4]=0x010000EF (jal x1,+16) -> ins_imm=0x10, rd_val=4; next mc_ins_addr=0x14.
3. mem[0x14]=0xFE000CE3 (beq x0,x0,-8) returned with stall=1 for 4 cycles -> ins_flag 0 throughout; one pulse in cycle after stall drops; ins_imm=0xFFFFFFF8; next addr 0x18.
4. clr=1, clr_pc=0x100 while in WAIT, mc_ins_valid same cycle -> no ins_flag, mc_ins_req drops; next request addr 0x100.
5. 0x40315113 (srai x2,x2,3) -> ins_imm=3. Then 0x123452B7 (lui x5,0x12345) -> ins_imm=0x12345000.
6. rdy=0 for 3 cycles in HOLD with stall=0 -> no state change, ins_flag 0; issue on first rdy=1 cycle. rst asserted in WAIT -> next-cycle outputs all 0, then request at RESET_PC.

Source files
------------

// File: rtl/ins_fetcher_pkg.sv
// ins_fetcher_pkg
//   Shared constants for the instruction-fetch front end:
//   - RV32I 7-bit opcode heads used by the immediate generator and next-PC logic
//   - fetch FSM state type
package ins_fetcher_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_WAIT = 2'd1,
    IF_HOLD = 2'd2
  } if_state_e;

endpackage

// File: rtl/ins_fetcher_imm_gen.sv
// imm_gen
//   Combinational RV32I immediate generator.
//   Ports:
//     ins  in  32  instruction word
//     imm  out 32  immediate (sign/zero-extended per opcode; 0 for R-type/unknown)
module imm_gen
  import ins_fetcher_pkg::*;
(
  input  logic [31:0] ins,
  output logic [31:0] imm
);

  always_comb begin
    imm = '0;
    case (ins[6:0])
      OPC_LOAD, OPC_JALR:
        imm = {{20{ins[31]}}, ins[31:20]};
      OPC_OPIMM: begin
        // Shift-immediates carry funct7 in ins[31:25]; only shamt is the operand.
        if (ins[13:12] == 2'b01)
          imm = {27'b0, ins[24:20]};
        else
          imm = {{20{ins[31]}}, ins[31:20]};
      end
      OPC_STORE:
        imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OPC_BRANCH:
        imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {ins[31:12], 12'b0};
      OPC_JAL:
        imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/ins_fetcher.sv
// ins_fetcher
//   Instruction-fetch front end: owns the PC, fetches one word at a time from
//   the memory controller, buffers it while the back end is stalled, and issues
//   it to the combinational decoder with a one-cycle strobe. JAL is redirected
//   statically; everything else falls through to pc+4. clr re-steers the PC.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     rdy                 global enable; low freezes all state (ins_flag forced 0)
//     stall               back end full; no issue while high
//     clr, clr_pc         flush and redirect target
//     mc_ins_req/addr     registered fetch request to memory controller
//     mc_ins_valid/data   returned instruction word (one-cycle pulse)
//     ins, ins_flag       issued instruction and issue strobe
//     ins_imm, rd_val     decoded immediate and PC of issued instruction
module ins_fetcher
  import ins_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        stall,
  input  logic        clr,
  input  logic [31:0] clr_pc,
  output logic        mc_ins_req,
  output logic [31:0] mc_ins_addr,
  input  logic        mc_ins_valid,
  input  logic [31:0] mc_ins_data,
  output logic [31:0] ins,
  output logic        ins_flag,
  output logic [31:0] ins_imm,
  output logic [31:0] rd_val
);

  if_state_e   state;
  logic [31:0] pc;
  logic [31:0] ins_buf;
  logic [31:0] issue_word;
  logic [31:0] issue_imm;
  logic [31:0] next_pc;

  // Both issue paths (direct from memory, or from the stall buffer) share one
  // immediate generator by muxing the word on the FSM state.
  always_comb begin
    issue_word = (state == IF_HOLD) ? ins_buf : mc_ins_data;
    next_pc    = (issue_word[6:0] == OPC_JAL) ? pc + issue_imm : pc + 32'd4;
  end

  imm_gen u_imm_gen (
    .ins (issue_word),
    .imm (issue_imm)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IF_IDLE;
      pc          <= RESET_PC;
      ins_buf     <= '0;
      mc_ins_req  <= 1'b0;
      mc_ins_addr <= '0;
      ins         <= '0;
      ins_flag    <= 1'b0;
      ins_imm     <= '0;
      rd_val      <= '0;
    end else if (!rdy) begin
      ins_flag <= 1'b0;
    end else if (clr) begin
      state      <= IF_IDLE;
      pc         <= clr_pc;
      ins_buf    <= '0;
      mc_ins_req <= 1'b0;
      ins_flag   <= 1'b0;
    end else begin
      ins_flag <= 1'b0;
      case (state)
        IF_IDLE: begin
          mc_ins_req  <= 1'b1;
          mc_ins_addr <= pc;
          state       <= IF_WAIT;
        end
        IF_WAIT: begin
          if (mc_ins_valid) begin
            mc_ins_req <= 1'b0;
            if (stall) begin
              ins_buf <= mc_ins_data;
              state   <= IF_HOLD;
            end else begin
              ins      <= issue_word;
              ins_imm  <= issue_imm;
              rd_val   <= pc;
              ins_flag <= 1'b1;
              pc       <= next_pc;
              state    <= IF_IDLE;
            end
          end
        end
        IF_HOLD: begin
          if (!stall) begin
            ins      <= issue_word;
            ins_imm  <= issue_imm;
            rd_val   <= pc;
            ins_flag <= 1'b1;
            pc       <= next_pc;
            state    <= IF_IDLE;
          end
        end
        default: state <= IF_IDLE;
      endcase
    end
  end

endmodule
